// File: rtl/icache_pkg.sv
// Shared definitions for the set-associative RVC instruction cache:
// FSM encoding, line geometry and halfword helpers.
package icache_pkg;

    localparam int LINE_W      = 128;
    localparam int HW_PER_LINE = 8;
    localparam int LADDR_W     = 28;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL_A = 2'd1,
        ST_FILL_B = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    // A halfword whose two low bits are 2'b11 starts a 32-bit instruction.
    function automatic logic is_rvc32(input logic [15:0] hw);
        return hw[1:0] == 2'b11;
    endfunction

    // Halfword number idx (0..7) of a 128-bit line.
    function automatic logic [15:0] line_hw(input logic [LINE_W-1:0] line,
                                            input logic [2:0] idx);
        return line[{idx, 4'b0000} +: 16];
    endfunction

endpackage

// File: rtl/icache_way_array.sv
// One way of the cache: valid, tag and line storage per set.
// Two independent lookup ports (line A and line B of a fetch), a valid
// probe for victim selection and one write port used by line fills.
module icache_way_array
    import icache_pkg::*;
#(
    parameter int SETS  = 8,
    parameter int IDX_W = 3,
    parameter int TAG_W = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  idx_a,
    input  logic [TAG_W-1:0]  tag_a,
    output logic              hit_a,
    output logic [LINE_W-1:0] data_a,
    input  logic [IDX_W-1:0]  idx_b,
    input  logic [TAG_W-1:0]  tag_b,
    output logic              hit_b,
    output logic [LINE_W-1:0] data_b,
    input  logic [IDX_W-1:0]  probe_idx,
    output logic              probe_valid,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_data
);

    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tags  [SETS];
    logic [LINE_W-1:0] lines [SETS];

    // Valid bits are the only state that must clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag and data payload; contents are meaningless until valid is set.
    always_ff @(posedge clk) begin
        if (we) begin
            tags[wr_idx]  <= wr_tag;
            lines[wr_idx] <= wr_data;
        end
    end

    assign hit_a       = valid[idx_a] && (tags[idx_a] == tag_a);
    assign hit_b       = valid[idx_b] && (tags[idx_b] == tag_b);
    assign data_a      = lines[idx_a];
    assign data_b      = lines[idx_b];
    assign probe_valid = valid[probe_idx];

endmodule

// File: rtl/icache_rvc_sa.sv
// Set-associative read-only instruction cache for RVC fetch.
// Returns one whole instruction per halfword-aligned address, fetching a
// second line when a 32-bit instruction straddles a line boundary.
// Handshake: proc_read is held by the core until a cycle where proc_stall
// is low; that cycle delivers proc_rdata/proc_ilen32. mem_read is held with
// a stable mem_addr until the single-cycle mem_ready pulse that carries
// mem_rdata.
module icache_rvc_sa
    import icache_pkg::*;
#(
    parameter int SETS = 8,
    parameter int WAYS = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               proc_read,
    input  logic [30:0]        proc_addr,
    output logic [31:0]        proc_rdata,
    output logic               proc_stall,
    output logic               proc_ilen32,
    output logic               mem_read,
    output logic               mem_write,
    output logic [LADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0]  mem_wdata,
    input  logic [LINE_W-1:0]  mem_rdata,
    input  logic               mem_ready
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = LADDR_W - IDX_W;

    state_t             state, state_n;
    logic [LADDR_W-1:0] line_a, line_b, fill_line;
    logic [2:0]         offset;
    logic [IDX_W-1:0]   idx_a, idx_b, fill_idx;
    logic [TAG_W-1:0]   tag_a, tag_b, fill_tag;
    logic [WAYS-1:0]    hit_a_v, hit_b_v, probe_v, we_v;
    logic [LINE_W-1:0]  data_a_w [WAYS];
    logic [LINE_W-1:0]  data_b_w [WAYS];
    logic [LINE_W-1:0]  data_a, data_b;
    logic               hit_a, hit_b, need_b, hit_all, fill_we, victim;
    logic [15:0]        hw_lo, hw_hi;

    // Line B is the sequential successor; the 28-bit add wraps to line 0.
    assign line_a   = proc_addr[30:3];
    assign line_b   = line_a + 28'd1;
    assign offset   = proc_addr[2:0];
    assign idx_a    = line_a[IDX_W-1:0];
    assign tag_a    = line_a[LADDR_W-1:IDX_W];
    assign idx_b    = line_b[IDX_W-1:0];
    assign tag_b    = line_b[LADDR_W-1:IDX_W];
    assign fill_idx = fill_line[IDX_W-1:0];
    assign fill_tag = fill_line[LADDR_W-1:IDX_W];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way_array #(
            .SETS  (SETS),
            .IDX_W (IDX_W),
            .TAG_W (TAG_W)
        ) u_way (
            .clk         (clk),
            .rst_n       (rst_n),
            .idx_a       (idx_a),
            .tag_a       (tag_a),
            .hit_a       (hit_a_v[w]),
            .data_a      (data_a_w[w]),
            .idx_b       (idx_b),
            .tag_b       (tag_b),
            .hit_b       (hit_b_v[w]),
            .data_b      (data_b_w[w]),
            .probe_idx   (fill_idx),
            .probe_valid (probe_v[w]),
            .we          (we_v[w]),
            .wr_idx      (fill_idx),
            .wr_tag      (fill_tag),
            .wr_data     (mem_rdata)
        );
        assign we_v[w] = fill_we && (victim == 1'(w));
    end

    // Select the hitting way's line; a miss yields zero so reset reads as 0.
    always_comb begin
        data_a = '0;
        data_b = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (hit_a_v[w]) data_a = data_a | data_a_w[w];
            if (hit_b_v[w]) data_b = data_b | data_b_w[w];
        end
    end

    assign hit_a = |hit_a_v;
    assign hit_b = |hit_b_v;

    // Halfword alignment and straddle detection.
    always_comb begin
        hw_lo  = line_hw(data_a, offset);
        need_b = (offset == 3'd7) && is_rvc32(hw_lo);
        if (offset != 3'd7) begin
            hw_hi = line_hw(data_a, offset + 3'd1);
        end else if (need_b) begin
            hw_hi = line_hw(data_b, 3'd0);
        end else begin
            hw_hi = 16'h0000;
        end
    end

    assign hit_all     = hit_a && (!need_b || hit_b);
    assign proc_stall  = proc_read && (!hit_all || (state != ST_IDLE));
    assign proc_rdata  = {hw_hi, hw_lo};
    assign proc_ilen32 = is_rvc32(hw_lo);
    assign mem_write   = 1'b0;
    assign mem_wdata   = '0;
    assign mem_addr    = fill_line;

    // Replacement: invalid way first (way 0 preferred), else the LRU way.
    if (WAYS == 2) begin : g_lru
        logic [SETS-1:0] lru;

        assign victim = !probe_v[0] ? 1'b0 : (!probe_v[1] ? 1'b1 : lru[fill_idx]);

        // LRU bit names the way to evict next; fills and accepted hits
        // point it at the way that was not just used.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lru <= '0;
            end else if (fill_we) begin
                lru[fill_idx] <= ~victim;
            end else if ((state == ST_IDLE) && proc_read && hit_all) begin
                lru[idx_a] <= ~hit_a_v[1];
                if (need_b) lru[idx_b] <= ~hit_b_v[1];
            end
        end
    end else begin : g_dm
        assign victim = 1'b0;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // FSM next state: line A misses are served before line B misses.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (proc_read && !hit_a) begin
                    state_n = ST_FILL_A;
                end else if (proc_read && need_b && !hit_b) begin
                    state_n = ST_FILL_B;
                end
            end
            ST_FILL_A, ST_FILL_B: begin
                if (mem_ready) state_n = ST_WAIT;
            end
            ST_WAIT: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // FSM outputs: memory request while filling, line write on mem_ready.
    always_comb begin
        mem_read = (state == ST_FILL_A) || (state == ST_FILL_B);
        fill_we  = mem_read && mem_ready;
    end

    // Latch the line to fetch when leaving IDLE so it stays stable even if
    // proc_addr changes during the fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_line <= '0;
        end else if ((state == ST_IDLE) && (state_n == ST_FILL_A)) begin
            fill_line <= line_a;
        end else if ((state == ST_IDLE) && (state_n == ST_FILL_B)) begin
            fill_line <= line_b;
        end
    end

endmodule

// File: doc/icache_rvc_sa.md
Name: icache_rvc_sa

Overview:
- Parametrised, set-associative, read-only instruction cache; successor to the direct-mapped read-only I-cache.
- Accepts halfword-aligned fetch addresses for the compressed (RVC) instruction extension and always returns one complete instruction, including 32-bit instructions that straddle two cache lines.
- Tells the core whether the returned instruction is 16 or 32 bits, so the PC advances by 2 or 4.
- Sits between the pipeline fetch stage and the slow instruction memory (128-bit line interface).

Parameters:
- SETS, 8, number of sets; power of two, at least 2; IDX_W = log2(SETS).
- WAYS, 2, associativity; legal values are 1 and 2.
- LINE_W, 128, line width in bits; fixed at 128 (8 halfwords per line).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- proc_read  in  1  fetch request, held until proc_stall is low
- proc_addr  in  31  halfword address (byte address bits [31:1])
- proc_rdata  out  32  instruction; bits [15:0] come from proc_addr
- proc_stall  out  1  high while the requested instruction is not yet available
- proc_ilen32  out  1  1 means the instruction is 32-bit (PC+4); 0 means 16-bit (PC+2)
- mem_read  out  1  line read request to slow memory
- mem_write  out  1  tied to 0
- mem_addr  out  28  line address (byte address bits [31:4])
- mem_wdata  out  128  tied to 0
- mem_rdata  in  128  returned line data
- mem_ready  in  1  one-cycle pulse; mem_rdata is valid in that cycle

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - all valid bits and LRU bits cleared; FSM goes to IDLE.
  - mem_read = 0, mem_addr = 0, proc_stall = 0, proc_rdata = 0, proc_ilen32 = 0.
  - a reset during a fill abandons the fill; a late mem_ready after reset is ignored in IDLE.
- Address split:
  - halfword offset = proc_addr[2:0]
  - index = proc_addr[3+IDX_W-1:3]
  - tag = the remaining upper bits.
- Lines involved in a fetch:
  - Line A = proc_addr[30:3].
  - Line B = A+1, modulo 2^28 (address 0xFFFFFFFE wraps Line B to line 0).
  - Line B is needed only when offset == 7 and A's halfword 7 has bits [1:0] == 2'b11 (32-bit instruction).
- Hit path (combinational, zero latency): when proc_read = 1 and every needed line hits, proc_stall = 0 in the same cycle.
  - proc_rdata[15:0] = halfword at the offset.
  - proc_rdata[31:16] = next halfword of Line A, or halfword 0 of Line B when Line B is needed.
  - For a 16-bit instruction at offset 7, proc_rdata[31:16] = 0.
  - proc_ilen32 = (proc_rdata[1:0] == 2'b11).
- proc_stall = proc_read AND (any needed line misses). proc_rdata and proc_ilen32 are don't-care while stalled.
- FSM states:
  - IDLE:
    - Line A miss -> FILL_A, with mem_read = 1 and mem_addr = A.
    - Line A hit but needed Line B miss -> FILL_B, with mem_addr = B.
  - FILL_A: hold mem_read and mem_addr until mem_ready.
    - On mem_ready, write the line into the victim way and set its valid bit.
    - Then go to WAIT (one cycle, mem_read = 0).
  - FILL_B: same as FILL_A, for Line B.
  - WAIT: return to IDLE. The lookup is re-evaluated there; a straddling fetch whose Line B still misses proceeds to FILL_B.
- mem_read falls in the cycle after mem_ready. At least one idle cycle separates consecutive mem_read requests.
- Replacement (WAYS = 2):
  - victim = an invalid way if one exists (way 0 first), otherwise the LRU way.
  - LRU bit per set updates on every hit (to the way not used) and on every fill.
  - Line A and Line B always map to different sets (SETS ≥ 2), so a Line B fill never evicts Line A.
- WAYS = 1: plain direct-mapped; LRU logic removed.
- proc_addr may change while stalled: the in-flight fill completes, and the lookup restarts against the new address.

Decomposition:
- Shared package icache_pkg holds:
  - FSM state encoding (IDLE, FILL_A, FILL_B, WAIT)
  - LINE_W, HW_PER_LINE = 8, line-address width 28
  - function is_rvc32(halfword) that checks bits [1:0] == 2'b11.
- One natural sub-module, icache_way_array: tag, valid and data storage for one way, with a hit-compare output; instantiated WAYS times.
- The top level holds the FSM, LRU, halfword alignment mux and straddle logic.

Test Plan:
- Cold miss, aligned: proc_addr = 0x0000_0008 (byte 0x10) -> proc_stall = 1, mem_read = 1, mem_addr = 0x0000001. Memory returns the line after 5 cycles -> stall falls in WAIT+1, with proc_rdata = the word at byte 0x10.
- Hit, compressed: the line at byte 0x10 holds 16'h4501 at byte 0x12; fetch proc_addr = 0x09 -> stall = 0 in the same cycle, proc_rdata[15:0] = 16'h4501, proc_ilen32 = 0.
- Straddle, 32-bit: halfword 7 of line 0x1 = 16'h0093 and both lines cold -> FILL_A (mem_addr = 0x1), then FILL_B (mem_addr = 0x2). Result: proc_rdata = {halfword 0 of line 0x2, 16'h0093}, proc_ilen32 = 1.
- Straddle, 16-bit: halfword 7 = 16'h8082 -> only one fill, no FILL_B, proc_rdata[31:16] = 0, proc_ilen32 = 0.
- LRU with SETS = 8, WAYS = 2: fill lines 0x0, 0x8, hit 0x0, then miss 0x10 -> 0x8 is evicted. A re-fetch of 0x0 hits; a fetch of 0x8 misses.
- Reset mid-fill and wrap-around:
  - rst_n low during FILL_A -> mem_read = 0 immediately and all lines invalid afterwards.
  - Fetch at byte 0xFFFFFFFE with a 32-bit instruction -> Line B mem_addr = 0x0000000.
